regfile_wr_arbiter: RTL and testbench
=====================================

// Module: regfile_wr_arbiter
// PURPOSE
//  Shares the single regfile write port (we3/wa3/wd3) between two writers:
//  in-order pipeline writeback (port P) and the long-latency unit (port L, e.g. mul/div).
//  Sits between writeback/long unit and decode's regfile; registered output, valid/ready per port.
//  P has priority; a starvation counter guarantees L forward progress.
// PARAMETERS
//  N          64  data width of regfile entries
//  STARVE_MAX 4   consecutive cycles L may wait with valid high before it is forced a grant (>=1)
// PORTS
//  clk         in   1   clock, rising edge
//  reset_n     in   1   asynchronous, active-low reset
//  p_valid     in   1   pipeline writeback request
//  p_ready     out  1   P request accepted this cycle
//  p_wa        in   5   P destination register
//  p_wd        in   N   P write data
//  l_valid     in   1   long-unit writeback request
//  l_ready     out  1   L request accepted this cycle
//  l_wa        in   5   L destination register
//  l_wd        in   N   L write data
//  we3         out  1   regfile write enable (registered)
//  wa3         out  5   regfile write address (registered)
//  wd3         out  N   regfile write data (registered)
//  grant_l     out  1   registered: 1 = current we3 write came from L (debug/scoreboard)
// BEHAVIOUR
//  Reset (async, reset_n=0): we3=0, wa3=0, wd3=0, grant_l=0, starve_cnt=0, state=PRIO_P.
//  Handshake: transfer on valid&&ready; ready is combinational from valids + state; ready never
//   high for both ports in one cycle; ready depends on no port's data.
//  Latency: request accepted in cycle t -> we3/wa3/wd3 driven in cycle t+1 for exactly one cycle.
//  No transfer in t -> we3=0 in t+1; wa3/wd3 hold previous values.
//  FSM (2 states):
//   PRIO_P: p_valid -> P granted; else l_valid -> L granted.
//           If l_valid && !l_ready: starve_cnt++ (saturating at STARVE_MAX).
//           starve_cnt==STARVE_MAX && l_valid -> next state PRIO_L.
//   PRIO_L: l_valid -> L granted, starve_cnt<=0, next PRIO_P; P stalls this cycle.
//           !l_valid (L withdrew; illegal but tolerated) -> behave as PRIO_P, go PRIO_P, cnt<=0.
//  starve_cnt clears whenever L is granted or l_valid is low.
//  x0: transfer to wa=0 completes handshake normally, but we3 stays 0 next cycle.
//  Same-address simultaneous requests: no merging/reordering; grant order alone decides
//   final regfile value (ordering hazards belong to the scoreboard, not this block).
//  Requesters must hold valid/wa/wd stable until ready; arbiter does not re-sample mid-wait.
//  Reset mid-operation: pending write in output register dropped (we3=0 immediately, async).
// STRUCTURE
//  Package regfile_pkg: typedef logic [4:0] reg_addr_t; localparam reg_addr_t REG_ZERO = 0;
//   typedef enum logic {PRIO_P, PRIO_L} wr_arb_state_t.
//  One natural sub-module: wr_port_reg (registered we/wa/wd/grant output stage, async-low reset).
//  Grant logic and starvation counter inline; counter width $clog2(STARVE_MAX+1).
// TESTING
//  1 Only p_valid, p_wa=5, p_wd=64'hDEAD -> p_ready=1 same cycle; next cycle we3=1, wa3=5, wd3=DEAD.
//  2 Both valid every cycle, STARVE_MAX=4 -> P granted 4 cycles, L granted 5th, pattern repeats.
//  3 Only l_valid, l_wa=0 -> l_ready=1; next cycle we3=0, grant_l stays 0.
//  4 Both valid, same wa=7, p_wd=1, l_wd=2, L forced next -> regfile x7 ends =2 (grant order).
//  5 reset_n low while we3=1 -> we3,wa3,wd3,grant_l =0 without clk edge; state PRIO_P after release.
//  6 Random valid streams 10k cycles -> never both ready; every L request granted within STARVE_MAX+1.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types for the regfile write-port arbiter: register address, x0 constant,
// and the two-state priority FSM encoding.
package regfile_pkg;

  typedef logic [4:0] reg_addr_t;

  localparam reg_addr_t REG_ZERO = 5'd0;

  typedef enum logic {
    PRIO_P = 1'b0,
    PRIO_L = 1'b1
  } wr_arb_state_t;

endpackage

// File: rtl/wr_port_reg.sv
// Registered regfile write stage: captures one accepted write and presents it for a
// single cycle. Writes to x0 are swallowed here so we/grant never assert for them.
module wr_port_reg
  import regfile_pkg::*;
#(
  parameter int unsigned N = 64
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_load,
  input  logic         i_from_l,
  input  logic [4:0]   i_wa,
  input  logic [N-1:0] i_wd,
  output logic         o_we,
  output logic [4:0]   o_wa,
  output logic [N-1:0] o_wd,
  output logic         o_grant_l
);

  logic         w_write;
  logic         r_we;
  logic         r_grant_l;
  reg_addr_t    r_wa;
  logic [N-1:0] r_wd;

  assign w_write = i_load && (i_wa != REG_ZERO);

  // Address/data only move on a real write, so they hold across idle cycles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_we      <= 1'b0;
      r_grant_l <= 1'b0;
      r_wa      <= REG_ZERO;
      r_wd      <= '0;
    end else begin
      r_we      <= w_write;
      r_grant_l <= w_write && i_from_l;
      if (w_write) begin
        r_wa <= i_wa;
        r_wd <= i_wd;
      end
    end
  end

  assign o_we      = r_we;
  assign o_wa      = r_wa;
  assign o_wd      = r_wd;
  assign o_grant_l = r_grant_l;

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Arbitrates the single regfile write port between pipeline writeback (P, priority)
// and the long-latency unit (L), with a starvation counter forcing L progress.
module regfile_wr_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned N          = 64,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         p_valid,
  output logic         p_ready,
  input  logic [4:0]   p_wa,
  input  logic [N-1:0] p_wd,
  input  logic         l_valid,
  output logic         l_ready,
  input  logic [4:0]   l_wa,
  input  logic [N-1:0] l_wd,
  output logic         we3,
  output logic [4:0]   wa3,
  output logic [N-1:0] wd3,
  output logic         grant_l
);

  localparam int unsigned CW = $clog2(STARVE_MAX + 1);

  wr_arb_state_t r_state;
  wr_arb_state_t w_state_nxt;
  logic [CW-1:0] r_starve_cnt;
  logic [CW-1:0] w_starve_cnt_nxt;
  logic          w_p_grant;
  logic          w_l_grant;
  logic [4:0]    w_sel_wa;
  logic [N-1:0]  w_sel_wd;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= PRIO_P;
      r_starve_cnt <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_starve_cnt <= w_starve_cnt_nxt;
    end
  end

  // Grant and starvation bookkeeping; the counter clears unless L waits with valid high.
  always_comb begin
    w_p_grant        = 1'b0;
    w_l_grant        = 1'b0;
    w_state_nxt      = PRIO_P;
    w_starve_cnt_nxt = '0;
    case (r_state)
      PRIO_P: begin
        w_p_grant = p_valid;
        w_l_grant = l_valid && !p_valid;
        if (l_valid && !w_l_grant) begin
          w_starve_cnt_nxt = (r_starve_cnt == CW'(STARVE_MAX)) ? r_starve_cnt
                                                               : r_starve_cnt + CW'(1);
          if (w_starve_cnt_nxt == CW'(STARVE_MAX)) begin
            w_state_nxt = PRIO_L;
          end
        end
      end
      PRIO_L: begin
        // A withdrawn L request falls back to normal P-first arbitration.
        if (l_valid) begin
          w_l_grant = 1'b1;
        end else begin
          w_p_grant = p_valid;
        end
      end
    endcase
  end

  assign p_ready  = w_p_grant;
  assign l_ready  = w_l_grant;
  assign w_sel_wa = w_l_grant ? l_wa : p_wa;
  assign w_sel_wd = w_l_grant ? l_wd : p_wd;

  wr_port_reg #(
    .N(N)
  ) u_wr_port_reg (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_load   (w_p_grant || w_l_grant),
    .i_from_l (w_l_grant),
    .i_wa     (w_sel_wa),
    .i_wd     (w_sel_wd),
    .o_we     (we3),
    .o_wa     (wa3),
    .o_wd     (wd3),
    .o_grant_l(grant_l)
  );

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Self-checking bench for regfile_wr_arbiter: directed scenarios plus a randomized
// run against a wait-count reference model of the arbitration rules.
module tb_regfile_wr_arbiter;

  localparam int unsigned N  = 64;
  localparam int unsigned SM = 4;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         p_valid, l_valid;
  logic         p_ready, l_ready;
  logic [4:0]   p_wa, l_wa;
  logic [N-1:0] p_wd, l_wd;
  logic         we3, grant_l;
  logic [4:0]   wa3;
  logic [N-1:0] wd3;

  int vecs = 0;
  int errs = 0;
  logic [N-1:0] rf [32];

  always #5 clk = ~clk;

  regfile_wr_arbiter #(.N(N), .STARVE_MAX(SM)) dut (
    .clk(clk), .reset_n(reset_n),
    .p_valid(p_valid), .p_ready(p_ready), .p_wa(p_wa), .p_wd(p_wd),
    .l_valid(l_valid), .l_ready(l_ready), .l_wa(l_wa), .l_wd(l_wd),
    .we3(we3), .wa3(wa3), .wd3(wd3), .grant_l(grant_l)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    p_valid = 1'b0; l_valid = 1'b0;
    p_wa = '0; l_wa = '0; p_wd = '0; l_wd = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    p_valid = 1'b0; l_valid = 1'b0;
    #3;
    vecs++;
    if ({we3, wa3, wd3, grant_l} !== '0) begin
      errs++; $display("FAIL reset_outputs: got we=%b wa=%0d wd=%h gl=%b required all 0", we3, wa3, wd3, grant_l);
    end
    vecs++;
    if ({p_ready, l_ready} !== 2'b00) begin
      errs++; $display("FAIL reset_idle_ready: got %b required 00", {p_ready, l_ready});
    end
    do_reset();
    l_valid = 1'b1; l_wa = 5'd3; l_wd = 64'h33;
    #1;
    vecs++;
    if ({p_ready, l_ready} !== 2'b01) begin
      errs++; $display("FAIL reset_l_only_ready: got %b required 01", {p_ready, l_ready});
    end
    l_valid = 1'b0;
    tick();
  endtask

  task automatic test_p_only();
    do_reset();
    p_valid = 1'b1; p_wa = 5'd5; p_wd = 64'hDEAD;
    #1;
    vecs++;
    if ({p_ready, l_ready} !== 2'b10) begin
      errs++; $display("FAIL p_only_ready: got %b required 10", {p_ready, l_ready});
    end
    tick();
    p_valid = 1'b0;
    vecs++;
    if (we3 !== 1'b1 || wa3 !== 5'd5 || wd3 !== 64'hDEAD || grant_l !== 1'b0) begin
      errs++; $display("FAIL p_only_write: got we=%b wa=%0d wd=%h gl=%b required 1 5 dead 0", we3, wa3, wd3, grant_l);
    end
    tick();
    vecs++;
    if (we3 !== 1'b0 || wa3 !== 5'd5 || wd3 !== 64'hDEAD) begin
      errs++; $display("FAIL p_only_idle_hold: got we=%b wa=%0d wd=%h required 0 5 dead", we3, wa3, wd3);
    end
  endtask

  task automatic test_starvation();
    logic exp_l;
    do_reset();
    p_valid = 1'b1; p_wa = 5'd1; p_wd = 64'h11;
    l_valid = 1'b1; l_wa = 5'd2; l_wd = 64'h22;
    for (int c = 0; c < 15; c++) begin
      exp_l = ((c % 5) == 4);
      #1;
      vecs++;
      if (l_ready !== exp_l || p_ready !== !exp_l) begin
        errs++; $display("FAIL starve_ready c%0d: got p=%b l=%b required p=%b l=%b", c, p_ready, l_ready, !exp_l, exp_l);
      end
      tick();
      vecs++;
      if (we3 !== 1'b1 || grant_l !== exp_l || wa3 !== (exp_l ? 5'd2 : 5'd1)) begin
        errs++; $display("FAIL starve_out c%0d: got we=%b gl=%b wa=%0d required 1 %b %0d", c, we3, grant_l, wa3, exp_l, exp_l ? 2 : 1);
      end
    end
    p_valid = 1'b0; l_valid = 1'b0;
    tick();
  endtask

  task automatic test_x0();
    do_reset();
    l_valid = 1'b1; l_wa = 5'd0; l_wd = {$urandom, $urandom};
    #1;
    vecs++;
    if ({p_ready, l_ready} !== 2'b01) begin
      errs++; $display("FAIL x0_ready: got %b required 01", {p_ready, l_ready});
    end
    tick();
    l_valid = 1'b0;
    vecs++;
    if (we3 !== 1'b0 || grant_l !== 1'b0) begin
      errs++; $display("FAIL x0_write: got we=%b gl=%b required 0 0", we3, grant_l);
    end
  endtask

  task automatic test_same_addr();
    int p_writes;
    bit l_done;
    do_reset();
    for (int i = 0; i < 32; i++) rf[i] = '0;
    p_writes = 0; l_done = 1'b0;
    p_valid = 1'b1; p_wa = 5'd7; p_wd = 64'd1;
    l_valid = 1'b1; l_wa = 5'd7; l_wd = 64'd2;
    for (int c = 0; c < 10 && !l_done; c++) begin
      #1;
      if (l_ready) l_done = 1'b1;
      tick();
      if (we3) begin
        rf[wa3] = wd3;
        if (!grant_l) p_writes++;
      end
      if (l_done) begin
        p_valid = 1'b0; l_valid = 1'b0;
      end
    end
    vecs++;
    if (!l_done) begin
      errs++; $display("FAIL same_addr_l_grant: got no l_ready within 10 cycles required grant");
    end
    vecs++;
    if (p_writes !== SM) begin
      errs++; $display("FAIL same_addr_p_writes: got %0d required %0d", p_writes, SM);
    end
    vecs++;
    if (rf[7] !== 64'd2) begin
      errs++; $display("FAIL same_addr_final: got x7=%h required 2", rf[7]);
    end
    p_valid = 1'b0; l_valid = 1'b0;
    tick();
  endtask

  task automatic test_async_reset();
    do_reset();
    l_valid = 1'b1; l_wa = 5'd9; l_wd = 64'hCAFE_F00D;
    tick();
    l_valid = 1'b0;
    vecs++;
    if (we3 !== 1'b1 || grant_l !== 1'b1) begin
      errs++; $display("FAIL areset_pre: got we=%b gl=%b required 1 1", we3, grant_l);
    end
    #1;
    reset_n = 1'b0;
    #1;
    vecs++;
    if ({we3, wa3, wd3, grant_l} !== '0) begin
      errs++; $display("FAIL areset_clear: got we=%b wa=%0d wd=%h gl=%b required all 0", we3, wa3, wd3, grant_l);
    end
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    p_valid = 1'b1; p_wa = 5'd4; p_wd = 64'h44;
    l_valid = 1'b1; l_wa = 5'd6; l_wd = 64'h66;
    #1;
    vecs++;
    if ({p_ready, l_ready} !== 2'b10) begin
      errs++; $display("FAIL areset_state: got %b required 10", {p_ready, l_ready});
    end
    p_valid = 1'b0; l_valid = 1'b0;
    tick();
  endtask

  task automatic test_random();
    int l_wait, l_obs;
    logic exp_p, exp_l, exp_we, exp_gl;
    logic [4:0] exp_wa;
    logic [N-1:0] exp_wd;
    logic got_p, got_l;
    do_reset();
    l_wait = 0; l_obs = 0;
    for (int c = 0; c < 10000; c++) begin
      if (!p_valid && ($urandom_range(0, 9) < 7)) begin
        p_valid = 1'b1; p_wa = 5'($urandom_range(0, 31)); p_wd = {$urandom, $urandom};
      end
      if (!l_valid && ($urandom_range(0, 9) < 5)) begin
        l_valid = 1'b1; l_wa = 5'($urandom_range(0, 31)); l_wd = {$urandom, $urandom};
      end
      #1;
      exp_l = l_valid && (!p_valid || l_wait == SM);
      exp_p = p_valid && !exp_l;
      got_p = p_ready; got_l = l_ready;
      vecs++;
      if (got_p !== exp_p || got_l !== exp_l) begin
        errs++; $display("FAIL rand_ready c%0d: got p=%b l=%b required p=%b l=%b", c, got_p, got_l, exp_p, exp_l);
      end
      vecs++;
      if (got_p && got_l) begin
        errs++; $display("FAIL rand_both_ready c%0d: got 11 required at most one", c);
      end
      if (l_valid && got_l) begin
        vecs++;
        if (l_obs > SM) begin
          errs++; $display("FAIL rand_l_latency c%0d: got %0d waits required <= %0d", c, l_obs, SM);
        end
        l_obs = 0;
      end else if (l_valid) begin
        l_obs++;
      end
      exp_wa = exp_l ? l_wa : p_wa;
      exp_wd = exp_l ? l_wd : p_wd;
      exp_we = (exp_p || exp_l) && (exp_wa != 5'd0);
      exp_gl = exp_we && exp_l;
      l_wait = (l_valid && !exp_l) ? ((l_wait < SM) ? l_wait + 1 : SM) : 0;
      tick();
      if (got_p) p_valid = 1'b0;
      if (got_l) l_valid = 1'b0;
      vecs++;
      if (we3 !== exp_we || grant_l !== exp_gl) begin
        errs++; $display("FAIL rand_we c%0d: got we=%b gl=%b required we=%b gl=%b", c, we3, grant_l, exp_we, exp_gl);
      end
      if (exp_we) begin
        vecs++;
        if (wa3 !== exp_wa || wd3 !== exp_wd) begin
          errs++; $display("FAIL rand_data c%0d: got wa=%0d wd=%h required wa=%0d wd=%h", c, wa3, wd3, exp_wa, exp_wd);
        end
      end
    end
    p_valid = 1'b0; l_valid = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_p_only();
    test_starvation();
    test_x0();
    test_same_addr();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
